// File: rtl/psmac_pkg.sv
// rtl/psmac_pkg.sv - shared constants and helpers for the PSMAC digit sequencer
package psmac_pkg;

  localparam int OPW  = 8;
  localparam int ACCW = 24;

  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of 2-bit digits per operand; the unused encoding 2'b11 behaves as 8-bit.
  function automatic logic [2:0] prec_digits(input logic [1:0] prec);
    case (prec)
      PREC_2B: prec_digits = 3'd1;
      PREC_4B: prec_digits = 3'd2;
      default: prec_digits = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rcbb.sv
// rtl/rcbb.sv - 2x2 signed/unsigned block multiplier producing a 5-bit two's-complement product
module rcbb (
  input  logic [1:0] md,
  input  logic [1:0] mr,
  input  logic       sx,
  input  logic       sy,
  output logic [4:0] p
);

  logic signed [2:0] x;
  logic signed [2:0] y;
  logic signed [5:0] prod;

  // A signed digit gets its top bit replicated; an unsigned one gets a zero.
  assign x    = {sx & md[1], md};
  assign y    = {sy & mr[1], mr};
  assign prod = x * y;
  assign p    = prod[4:0];

endmodule

// File: rtl/psmac_digit_seq.sv
// rtl/psmac_digit_seq.sv - digit-serial precision-scalable multiply-accumulate sequencer
module psmac_digit_seq
  import psmac_pkg::*;
#(
  parameter int OPW  = 8,
  parameter int ACCW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      prec,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic            sa,
  input  logic            sb,
  input  logic            acc_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc
);

  logic [1:0]      state;
  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic            sa_q;
  logic            sb_q;
  logic [2:0]      n_q;
  logic [1:0]      i_q;
  logic [1:0]      j_q;
  logic [ACCW-1:0] acc_q;

  logic [2:0]      n_m1;
  logic            i_last;
  logic            j_last;
  logic [1:0]      md;
  logic [1:0]      mr;
  logic [4:0]      p;
  logic [3:0]      shamt;
  logic [ACCW-1:0] p_ext;
  logic [ACCW-1:0] sum;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign n_m1   = n_q - 3'd1;
  assign i_last = ({1'b0, i_q} == n_m1);
  assign j_last = ({1'b0, j_q} == n_m1);

  assign md = a_q[{i_q, 1'b0} +: 2];
  assign mr = b_q[{j_q, 1'b0} +: 2];

  rcbb u_bb (
    .md (md),
    .mr (mr),
    .sx (sa_q & i_last),
    .sy (sb_q & j_last),
    .p  (p)
  );

  // Partial product weight is 4^(i+j).
  assign shamt = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
  assign p_ext = {{(ACCW-5){p[4]}}, p};
  assign sum   = acc_q + (p_ext << shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      n_q     <= 3'd1;
      i_q     <= 2'd0;
      j_q     <= 2'd0;
      acc_q   <= '0;
      out_acc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sa_q  <= sa;
            sb_q  <= sb;
            n_q   <= prec_digits(prec);
            i_q   <= 2'd0;
            j_q   <= 2'd0;
            acc_q <= acc_clr ? '0 : acc_q;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc_q <= sum;
          if (j_last) begin
            j_q <= 2'd0;
            if (i_last) begin
              out_acc <= sum;
              state   <= ST_DONE;
            end else begin
              i_q <= i_q + 2'd1;
            end
          end else begin
            j_q <= j_q + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psmac_digit_seq.sv
// tb/tb_psmac_digit_seq.sv - directed and randomised self-checking bench for psmac_digit_seq
module tb_psmac_digit_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  prec;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sa;
  logic        sb;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_acc;

  int n_checks = 0;
  int n_pass   = 0;

  psmac_digit_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prec      (prec),
    .a         (a),
    .b         (b),
    .sa        (sa),
    .sb        (sb),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  function automatic longint ref_val(input logic [7:0] x, input logic [1:0] pr, input logic s);
    int     w;
    longint v;
    w = (pr == 2'b00) ? 2 : (pr == 2'b01) ? 4 : 8;
    v = longint'(x) & ((longint'(1) << w) - 1);
    if (s && v[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic int digits(input logic [1:0] pr);
    return (pr == 2'b00) ? 1 : (pr == 2'b01) ? 2 : 4;
  endfunction

  // Presents one operand set, takes it on the next edge, then scrambles the inputs.
  task automatic start_op(input logic [1:0] pr, input logic [7:0] av, input logic [7:0] bv,
                          input logic s_a, input logic s_b, input logic clr);
    prec = pr; a = av; b = bv; sa = s_a; sb = s_b; acc_clr = clr; in_valid = 1'b1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    prec = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
    sa = 1'($urandom); sb = 1'($urandom); acc_clr = 1'($urandom);
  endtask

  task automatic wait_result(input int exp_lat, input logic [23:0] exp_acc);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("out_acc", {8'd0, out_acc}, {8'd0, exp_acc});
  endtask

  task automatic release_result(input int stall, input logic [23:0] exp_acc);
    repeat (stall) begin
      @(posedge clk); #1;
      check("stall_out_acc", {8'd0, out_acc}, {8'd0, exp_acc});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_op(input logic [1:0] pr, input logic [7:0] av, input logic [7:0] bv,
                       input logic s_a, input logic s_b, input logic clr,
                       input logic [23:0] exp_acc, input int stall);
    int n;
    n = digits(pr);
    start_op(pr, av, bv, s_a, s_b, clr);
    wait_result(n * n, exp_acc);
    release_result(stall, exp_acc);
  endtask

  initial begin
    logic [23:0] macc;
    logic [23:0] e;
    logic [1:0]  rp;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rsa;
    logic        rsb;
    logic        rclr;
    longint      prod;

    rst_n = 1'b0; in_valid = 1'b0; prec = 2'b00; a = '0; b = '0;
    sa = 1'b0; sb = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_acc", {8'd0, out_acc}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-digit signed: -2 * -1
    do_op(2'b00, 8'b0000_0010, 8'b0000_0011, 1'b1, 1'b1, 1'b1, 24'd2, 0);
    // 4-bit unsigned and signed
    do_op(2'b01, 8'd15, 8'd15, 1'b0, 1'b0, 1'b1, 24'd225, 1);
    do_op(2'b01, 8'd15, 8'd15, 1'b1, 1'b1, 1'b1, 24'd1, 0);
    // 8-bit signed extremes
    do_op(2'b10, 8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 24'd16384, 2);
    e = -24'd16256;
    do_op(2'b10, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, e, 0);
    // Bits above the selected precision are ignored
    do_op(2'b00, 8'hFE, 8'hF3, 1'b0, 1'b0, 1'b1, 24'd6, 0);
    // prec=11 behaves as 8-bit
    do_op(2'b11, 8'd200, 8'd3, 1'b0, 1'b0, 1'b1, 24'd600, 0);

    // Accumulation chain
    do_op(2'b10, 8'd3, 8'd4, 1'b0, 1'b0, 1'b1, 24'd12, 0);
    do_op(2'b10, 8'd5, 8'd6, 1'b0, 1'b0, 1'b0, 24'd42, 0);
    do_op(2'b10, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 24'd1, 0);

    // Backpressure with ignored in_valid pulses
    start_op(2'b01, 8'd7, 8'd9, 1'b0, 1'b0, 1'b1);
    wait_result(4, 24'd63);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_acc", {8'd0, out_acc}, 32'd63);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    // Accumulator untouched by the ignored pulses: 63 + 2*2
    do_op(2'b01, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 24'd67, 0);

    // Reset in the middle of an 8-bit multiply
    start_op(2'b10, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset_out_acc", {8'd0, out_acc}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b10, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 24'd6, 0);

    // Randomised ops against a full-width signed reference
    macc = 24'd6;
    for (int t = 0; t < 300; t++) begin
      rp   = 2'($urandom);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rsa  = 1'($urandom);
      rsb  = 1'($urandom);
      rclr = ($urandom_range(0, 3) == 0);
      prod = ref_val(ra, rp, rsa) * ref_val(rb, rp, rsb);
      e    = (rclr ? 24'd0 : macc) + 24'(prod);
      macc = e;
      do_op(rp, ra, rb, rsa, rsb, rclr, e, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
